// File: rtl/fa_structural_if.sv
// Bundles the full-adder data inputs with its combinational and registered results.
// clk and rst are plain ports on the adder, so they are not part of this bundle.
interface fa_structural_if;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout,
        input  sum_q,
        input  cout_q
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout,
        output sum_q,
        output cout_q
    );
endinterface

// File: rtl/fa_structural.sv
// Gate-level full adder: two half adders plus an OR for the carry.
// Registered copies of sum and carry-out are provided for pipelined users.
module fa_structural (
    input  logic            clk,
    input  logic            rst,
    fa_structural_if.slave  bus
);
    logic a_w;
    logic b_w;
    logic cin_w;
    logic p_w;
    logic g1_w;
    logic g2_w;
    logic sum_w;
    logic cout_w;
    logic sum_d;
    logic cout_d;
    logic sum_q;
    logic cout_q;

    assign a_w   = bus.a;
    assign b_w   = bus.b;
    assign cin_w = bus.cin;

    // Half adder 1 forms propagate/generate from the addends.
    xor u_ha1_xor (p_w, a_w, b_w);
    and u_ha1_and (g1_w, a_w, b_w);

    // Half adder 2 folds in the carry-in.
    xor u_ha2_xor (sum_w, p_w, cin_w);
    and u_ha2_and (g2_w, p_w, cin_w);

    or  u_cout_or (cout_w, g1_w, g2_w);

    assign sum_d  = sum_w;
    assign cout_d = cout_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum    = sum_w;
    assign bus.cout   = cout_w;
    assign bus.sum_q  = sum_q;
    assign bus.cout_q = cout_q;
endmodule

// File: tb/tb_fa_structural.sv
// Bench for fa_structural: directed cases from the adder's truth table plus a
// randomized run checked every cycle against an arithmetic model.
module tb_fa_structural;
    logic clk;
    logic clk_en;
    logic rst;
    int   n_total;
    int   n_pass;

    fa_structural_if bus ();

    fa_structural dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    // Reference: the two-bit value {cout,sum} is just the integer a+b+cin.
    function automatic logic [1:0] model_add(input logic a, input logic b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return s[1:0];
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {cout,sum}=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Model of the registered path: captures a+b+cin (or 0 under reset) at each edge.
    logic [1:0] exp_reg;
    logic       model_valid;
    initial model_valid = 1'b0;
    always @(posedge clk) begin
        exp_reg     <= rst ? 2'b00 : model_add(bus.a, bus.b, bus.cin);
        model_valid <= 1'b1;
    end

    // Every-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (clk_en && model_valid) begin
            chk("cyc_comb", {bus.cout, bus.sum}, model_add(bus.a, bus.b, bus.cin));
            chk("cyc_reg", {bus.cout_q, bus.sum_q}, exp_reg);
        end
    end

    logic [1:0] sweep_exp [8];
    logic [2:0] v;

    initial begin
        n_total = 0;
        n_pass  = 0;
        clk_en  = 1'b0;
        rst     = 1'b0;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.cin = 1'b0;
        // {cout,sum} for {a,b,cin} = 0..7, straight from the truth table.
        sweep_exp[0] = 2'b00; sweep_exp[1] = 2'b01;
        sweep_exp[2] = 2'b01; sweep_exp[3] = 2'b10;
        sweep_exp[4] = 2'b01; sweep_exp[5] = 2'b10;
        sweep_exp[6] = 2'b10; sweep_exp[7] = 2'b11;

        // Combinational sweep with no clock activity.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {bus.a, bus.b, bus.cin} = v;
            #10;
            chk("sweep_table", {bus.cout, bus.sum}, sweep_exp[i]);
            chk("sweep_model", {bus.cout, bus.sum}, model_add(v[2], v[1], v[0]));
        end

        // Carry propagation: a=1, b=0, cin 0->1->0.
        bus.a = 1'b1; bus.b = 1'b0; bus.cin = 1'b0; #10;
        chk("carry_0", {bus.cout, bus.sum}, 2'b01);
        bus.cin = 1'b1; #10;
        chk("carry_1", {bus.cout, bus.sum}, 2'b10);
        bus.cin = 1'b0; #10;
        chk("carry_2", {bus.cout, bus.sum}, 2'b01);

        // Start the clock and apply reset.
        clk_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_state", {bus.cout_q, bus.sum_q}, 2'b00);

        // Registered path capture, then a mid-cycle input change.
        rst = 1'b0; bus.a = 1'b1; bus.b = 1'b1; bus.cin = 1'b1;
        @(posedge clk); #1;
        chk("reg_capture", {bus.cout_q, bus.sum_q}, 2'b11);
        #3 bus.a = 1'b0; #1;
        chk("reg_hold_midcycle", {bus.cout_q, bus.sum_q}, 2'b11);
        chk("comb_midcycle", {bus.cout, bus.sum}, 2'b10);
        @(posedge clk); #1;
        chk("reg_next_edge", {bus.cout_q, bus.sum_q}, 2'b10);

        // Synchronous reset wins over capture; combinational path unaffected.
        bus.a = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("sync_reset_reg", {bus.cout_q, bus.sum_q}, 2'b00);
        chk("sync_reset_comb", {bus.cout, bus.sum}, 2'b11);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_release", {bus.cout_q, bus.sum_q}, 2'b11);

        // Reset pulse entirely between edges has no effect.
        rst = 1'b1; #2; rst = 1'b0; #1;
        chk("rst_between_mid", {bus.cout_q, bus.sum_q}, 2'b11);
        @(posedge clk); #1;
        chk("rst_between_edge", {bus.cout_q, bus.sum_q}, 2'b11);

        // Arithmetic cross-check on the registered path.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {bus.a, bus.b, bus.cin} = v;
            @(posedge clk); #1;
            chk("arith_reg", {bus.cout_q, bus.sum_q}, sweep_exp[i]);
        end

        // Randomized run; the negedge compare process checks every cycle.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            bus.a   = 1'($urandom);
            bus.b   = 1'($urandom);
            bus.cin = 1'($urandom);
            rst     = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        clk_en = 1'b0;
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fa_structural.md
# fa_structural

Single-bit full adder built structurally from gate primitives: two half adders plus an OR for the carry. It is the leaf cell for ripple-carry adders and other arithmetic blocks. The sum and carry-out are available combinationally. A registered copy of both is provided for pipelined users.

## Interface
- No parameters.
- clk  input  1  system clock; rising edge; drives only the registered outputs.
- rst  input  1  synchronous, active-high reset; affects only the registered outputs.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry-in bit.
- sum  output  1  combinational sum, a ^ b ^ cin.
- cout  output  1  combinational carry-out, (a & b) | (cin & (a ^ b)).
- sum_q  output  1  sum registered on the rising edge of clk.
- cout_q  output  1  cout registered on the rising edge of clk.

## Operation
- Structural decomposition, using gate primitives or instantiated half-adder cells, with no behavioural arithmetic operators:
  - HA1: p = a ^ b, g1 = a & b.
  - HA2: sum = p ^ cin, g2 = p & cin.
  - cout = g1 | g2.
- Truth table (a b cin -> sum cout):
  - 000->00, 001->10, 010->10, 011->01.
  - 100->10, 101->01, 110->01, 111->11.
- Equivalent arithmetic: {cout, sum} = a + b + cin, a 2-bit result in the range 0..3.
- The combinational path (sum, cout) has no dependence on clk or rst. It produces correct values even when clk and rst are left unconnected (z).
- Registered path:
  - On each rising clk edge, if rst = 1: sum_q <= 0, cout_q <= 0.
  - Otherwise: sum_q <= sum, cout_q <= cout.
- No internal state besides the two output flops.
- X/Z on a data input propagates per gate semantics; no masking.

## Timing
- sum and cout are purely combinational, with zero cycle latency. They must settle within one gate-delay chain: XOR-XOR for sum, XOR-AND-OR for cout. Unit-delay simulation settles well within 10 ns.
- sum_q and cout_q have 1-cycle latency: they reflect inputs sampled at the capturing rising edge.
- Reset values: sum_q = 0, cout_q = 0.
  - Reset is evaluated only at clock edges; asserting rst between edges does not change the outputs until the next edge.
  - rst asserted at an edge wins over the data capture.
  - Deasserting rst resumes capture at the next edge.
- Before the first clock edge, sum_q and cout_q are X unless reset has been applied. sum and cout are valid immediately.
- Input changes between clock edges affect sum and cout at once and sum_q and cout_q only at the next edge.

## Test plan
- Exhaustive combinational sweep: apply all 8 {a,b,cin} combinations, 10 ns apart, with clk and rst unconnected. The required sum/cout are 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- Carry propagation: a=1, b=0, cin toggling 0->1->0. Required: sum 1->0->1 and cout 0->1->0 within 10 ns of each change.
- Registered path: with rst=0, drive a=1, b=1, cin=1 before an edge. Required: sum_q=1 and cout_q=1 after that edge; unchanged if inputs change mid-cycle.
- Synchronous reset: hold a=b=cin=1, assert rst for one edge. Required: sum_q=0 and cout_q=0 after that edge, while sum=1 and cout=1 throughout. Deassert rst; both flops read 1 after the next edge.
- Reset between edges: pulse rst high and low entirely between two rising edges. Required: sum_q and cout_q are unaffected.
- Arithmetic cross-check: for all 8 inputs, check that {cout,sum} == a+b+cin both combinationally and one cycle later on {cout_q,sum_q}.
